dma_requester: RTL and testbench
================================

DMA_REQUESTER -- requirements
Module: dma_requester

Interface
REQ-001 SHALL have parameter PROCSIZE, default 4, meaning the local-memory address width.
REQ-002 SHALL have parameter SIZE, default 4, meaning the shared-memory pointer width.
REQ-003 SHALL have parameter WORD_SIZE, default 16, meaning the data word width.
REQ-004 SHALL have parameter PAGES_COUNT, default 2, meaning the page-number width.
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning the maximum wait for ack, in cycles.
REQ-006 clock  in  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 cmd_valid  in  1  core requests a transfer.
REQ-009 cmd_ready  out  1  requester accepts a command this cycle.
REQ-010 cmd_action  in  1  0=READ (shared->local), 1=WRITE (local->shared).
REQ-011 cmd_ptr / cmd_start / cmd_length  in  SIZE / PROCSIZE / PROCSIZE  shared pointer, local start address, word count.
REQ-012 trigger  out  1  toggle-type request to the DMA engine.
REQ-013 ack  in  1  toggle-type completion from the DMA engine.
REQ-014 action / ptr / copy_start / copy_length  out  1 / SIZE / PROCSIZE / PROCSIZE  latched command presented to the DMA.
REQ-015 ptr_out  in  PAGES_COUNT  page returned by the DMA on WRITE.
REQ-016 busy  out  1  transfer outstanding.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 timeout  out  1  one-cycle abort pulse.
REQ-019 result_page  out  PAGES_COUNT  page captured at WRITE completion.
REQ-020 core_mem_addr / core_mem_data_out / core_mem_rw  in  PROCSIZE / WORD_SIZE / 1  core access to local memory.
REQ-021 dma_mem_addr / dma_mem_data_out / dma_mem_rw  in  PROCSIZE / WORD_SIZE / 1  DMA access to local memory.
REQ-022 mem_addr / mem_data_in / mem_rw  out  PROCSIZE / WORD_SIZE / 1  muxed local-memory port.
REQ-023 core_stall  out  1  core access is blocked.

Function
REQ-024 FSM states: SYNC, IDLE, ISSUE, WAIT_ACK, DONE.
REQ-025 SYNC lasts exactly one cycle: last_ack <= ack, then go to IDLE.
REQ-026 In IDLE, cmd_ready=1; cmd_valid=1 latches action/ptr/copy_start/copy_length from cmd_* and moves to ISSUE.
REQ-027 A command with length 0 skips ISSUE and goes IDLE->DONE, with trigger unchanged.
REQ-028 ISSUE toggles trigger exactly once, clears the wait counter, and moves to WAIT_ACK the next cycle.
REQ-029 WAIT_ACK: ack != last_ack -> last_ack <= ack; result_page <= ptr_out if action=WRITE; go to DONE.
REQ-030 WAIT_ACK: counter reaching TIMEOUT without an ack edge -> timeout pulse, then IDLE; trigger is not toggled back.
REQ-031 An ack edge in the same cycle that the counter reaches TIMEOUT counts as completion; no timeout pulse.
REQ-032 DONE asserts done for one cycle, then returns to IDLE.
REQ-033 busy=1 in ISSUE and WAIT_ACK; cmd_ready=0 outside IDLE; commands outside IDLE are ignored, not queued.
REQ-034 Latched outputs stay stable from acceptance until the next acceptance.
REQ-035 While in WAIT_ACK: mem_* driven from dma_mem_*, core_stall=1.
REQ-036 Otherwise: mem_* driven from core_mem_*, core_stall=0.
REQ-037 The mem_* mux is combinational.
REQ-038 An ack edge seen in IDLE, ISSUE or DONE updates last_ack and is otherwise ignored.
REQ-039 All counters wrap-free; the wait counter saturates at TIMEOUT.

Reset
REQ-040 reset_n=0 immediately forces state=SYNC.
REQ-041 Reset values: trigger=0, last_ack=0, busy=0, done=0, timeout=0, cmd_ready=0, result_page=0, action/ptr/copy_start/copy_length=0, wait counter=0.
REQ-042 Reset mid-transfer abandons the transfer with no done pulse; SYNC re-aligns last_ack to the current ack level, so no false completion occurs.

Verification
REQ-043 Reset, ack=0; WRITE, ptr=0, start=2, length=3 -> trigger 0->1 one cycle after ISSUE; ack toggles 5 cycles later with ptr_out=1 -> done pulse, result_page=1, busy=0.
REQ-044 READ, length=0 -> done one cycle after acceptance, trigger unchanged, core_stall never asserted.
REQ-045 During WAIT_ACK: dma_mem_addr=5, core_mem_addr=9 -> mem_addr=5, core_stall=1; after done -> mem_addr=9.
REQ-046 TIMEOUT=8, ack never toggles -> timeout pulse at the 8th WAIT_ACK cycle, no done, cmd_ready=1 next cycle.
REQ-047 Assert reset_n during WAIT_ACK while ack=1 -> outputs at reset values; after SYNC, no done pulse; next command completes only on a 1->0 ack edge.
REQ-048 cmd_valid held high during WAIT_ACK with a different ptr -> latched ptr unchanged until the next IDLE acceptance.

Source files
------------

// File: rtl/dma_requester.sv
// Toggle-handshake DMA command requester: latches one core command, raises a
// trigger edge, waits for the matching ack edge (or a timeout) and muxes the local-memory port.
module dma_requester #(
  parameter int PROCSIZE    = 4,
  parameter int SIZE        = 4,
  parameter int WORD_SIZE   = 16,
  parameter int PAGES_COUNT = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_action,
  input  logic [SIZE-1:0]        cmd_ptr,
  input  logic [PROCSIZE-1:0]    cmd_start,
  input  logic [PROCSIZE-1:0]    cmd_length,
  output logic                   trigger,
  input  logic                   ack,
  output logic                   action,
  output logic [SIZE-1:0]        ptr,
  output logic [PROCSIZE-1:0]    copy_start,
  output logic [PROCSIZE-1:0]    copy_length,
  input  logic [PAGES_COUNT-1:0] ptr_out,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [PAGES_COUNT-1:0] result_page,
  input  logic [PROCSIZE-1:0]    core_mem_addr,
  input  logic [WORD_SIZE-1:0]   core_mem_data_out,
  input  logic                   core_mem_rw,
  input  logic [PROCSIZE-1:0]    dma_mem_addr,
  input  logic [WORD_SIZE-1:0]   dma_mem_data_out,
  input  logic                   dma_mem_rw,
  output logic [PROCSIZE-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0]   mem_data_in,
  output logic                   mem_rw,
  output logic                   core_stall
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {SYNC, IDLE, ISSUE, WAIT_ACK, DONE} state_t;

  state_t           state, state_nx;
  logic             last_ack;
  logic [CNT_W-1:0] wait_cnt;
  logic             ack_edge;
  logic             wait_expire;
  logic             accept;

  assign ack_edge    = ack ^ last_ack;
  assign wait_expire = (wait_cnt == TIMEOUT_CNT - 1'b1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    // NOTE: every register is written with <= so all flops sample the same pre-edge values.
    else          state <= state_nx;
  end

  // An ack edge arriving together with the final wait cycle wins over the timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    accept    = 1'b0;
    case (state)
      SYNC: state_nx = IDLE;
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept   = 1'b1;
          state_nx = (cmd_length == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        busy = 1'b1;
        if (ack_edge) begin
          state_nx = DONE;
        end else if (wait_expire) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = SYNC;
    endcase
  end

  // last_ack tracks ack every cycle, so edges outside WAIT_ACK are simply absorbed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_ack    <= 1'b0;
      trigger     <= 1'b0;
      action      <= 1'b0;
      ptr         <= '0;
      copy_start  <= '0;
      copy_length <= '0;
      result_page <= '0;
      wait_cnt    <= '0;
    end else begin
      last_ack <= ack;
      if (accept) begin
        action      <= cmd_action;
        ptr         <= cmd_ptr;
        copy_start  <= cmd_start;
        copy_length <= cmd_length;
      end
      if (state == ISSUE) begin
        trigger  <= ~trigger;
        wait_cnt <= '0;
      end else if (state == WAIT_ACK) begin
        if (ack_edge && action) result_page <= ptr_out;
        if (wait_cnt != TIMEOUT_CNT) wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    core_stall  = 1'b0;
    mem_addr    = core_mem_addr;
    mem_data_in = core_mem_data_out;
    mem_rw      = core_mem_rw;
    if (state == WAIT_ACK) begin
      core_stall  = 1'b1;
      mem_addr    = dma_mem_addr;
      mem_data_in = dma_mem_data_out;
      mem_rw      = dma_mem_rw;
    end
  end

endmodule

// File: tb/tb_dma_requester.sv
// Bench for dma_requester: directed scenarios plus randomized transfers checked
// against a transaction-level model of the trigger/ack handshake.
module tb_dma_requester;

  localparam int PS = 4;
  localparam int SZ = 4;
  localparam int WS = 16;
  localparam int PC = 2;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_action = 1'b0;
  logic [SZ-1:0] cmd_ptr = '0;
  logic [PS-1:0] cmd_start = '0, cmd_length = '0;
  logic          ack = 1'b0;
  logic [PC-1:0] ptr_out = '0;
  logic [PS-1:0] core_mem_addr = '0, dma_mem_addr = '0;
  logic [WS-1:0] core_mem_data_out = '0, dma_mem_data_out = '0;
  logic          core_mem_rw = 1'b0, dma_mem_rw = 1'b0;

  logic          cmd_ready, trigger, action, busy, done, timeout, mem_rw, core_stall;
  logic [SZ-1:0] ptr;
  logic [PS-1:0] copy_start, copy_length, mem_addr;
  logic [PC-1:0] result_page;
  logic [WS-1:0] mem_data_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level expectations
  logic          exp_trigger = 1'b0;
  logic [PC-1:0] exp_rp = '0;
  logic          exp_act = 1'b0;
  logic [SZ-1:0] exp_ptr = '0;
  logic [PS-1:0] exp_start = '0, exp_len = '0;

  dma_requester #(.PROCSIZE(PS), .SIZE(SZ), .WORD_SIZE(WS), .PAGES_COUNT(PC), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_action(cmd_action),
    .cmd_ptr(cmd_ptr), .cmd_start(cmd_start), .cmd_length(cmd_length),
    .trigger(trigger), .ack(ack),
    .action(action), .ptr(ptr), .copy_start(copy_start), .copy_length(copy_length),
    .ptr_out(ptr_out), .busy(busy), .done(done), .timeout(timeout), .result_page(result_page),
    .core_mem_addr(core_mem_addr), .core_mem_data_out(core_mem_data_out), .core_mem_rw(core_mem_rw),
    .dma_mem_addr(dma_mem_addr), .dma_mem_data_out(dma_mem_data_out), .dma_mem_rw(dma_mem_rw),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rw(mem_rw), .core_stall(core_stall)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if ({cmd_ready, busy, done, timeout, core_stall, trigger, result_page} !== {5'b10000, exp_trigger, exp_rp}) begin
      n_fail++;
      $display("FAIL %s idle: got rdy/busy/done/to/stall=%b trig=%b rp=%0d, want 10000 trig=%b rp=%0d",
               tag, {cmd_ready, busy, done, timeout, core_stall}, trigger, result_page, exp_trigger, exp_rp);
    end
    n_checks++;
    if ({action, ptr, copy_start, copy_length} !== {exp_act, exp_ptr, exp_start, exp_len}) begin
      n_fail++;
      $display("FAIL %s latched: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", tag,
               action, ptr, copy_start, copy_length, exp_act, exp_ptr, exp_start, exp_len);
    end
  endtask

  // One full command from IDLE back to IDLE. d = WAIT_ACK cycles that pass before ack toggles;
  // d >= TO means ack never toggles and the transfer must time out.
  task automatic run_txn(input string tag, input logic act, input logic [SZ-1:0] p,
                         input logic [PS-1:0] st, input logic [PS-1:0] len, input int d,
                         input logic [PC-1:0] pout, input bit hold, input bit fixed);
    logic [PS-1:0] ca, da;
    logic [WS-1:0] cd, dd;
    logic          crw, drw;
    bit            completed;
    check_idle({tag, "_pre"});
    cmd_valid = 1'b1; cmd_action = act; cmd_ptr = p; cmd_start = st; cmd_length = len;
    tick();
    exp_act = act; exp_ptr = p; exp_start = st; exp_len = len;
    if (hold && len != 0) begin
      cmd_action = ~act; cmd_ptr = p + 1'b1; cmd_start = st + 1'b1; cmd_length = len + 1'b1;
    end else begin
      cmd_valid = 1'b0;
    end
    completed = 1'b0;
    if (len == 0) begin
      completed = 1'b1;
    end else begin
      n_checks++;
      if ({cmd_ready, busy, done, timeout, core_stall, trigger} !== {5'b01000, exp_trigger}) begin
        n_fail++;
        $display("FAIL %s issue: got rdy/busy/done/to/stall/trig=%b want 01000%b", tag,
                 {cmd_ready, busy, done, timeout, core_stall, trigger}, exp_trigger);
      end
      tick();
      exp_trigger = ~exp_trigger;
      for (int i = 1; i <= TO; i++) begin
        ca = fixed ? PS'(9) : PS'($urandom); da = fixed ? PS'(5) : PS'($urandom);
        cd = WS'($urandom); dd = WS'($urandom); crw = 1'($urandom); drw = 1'($urandom);
        core_mem_addr = ca; dma_mem_addr = da; core_mem_data_out = cd; dma_mem_data_out = dd;
        core_mem_rw = crw; dma_mem_rw = drw;
        ptr_out = PC'($urandom);
        if (d < TO && i == d + 1) begin
          ack = ~ack; ptr_out = pout; completed = 1'b1;
        end
        if (completed || i == TO) cmd_valid = 1'b0;
        #1;
        n_checks++;
        if ({mem_addr, mem_data_in, mem_rw} !== {da, dd, drw}) begin
          n_fail++;
          $display("FAIL %s wait%0d mux: got %0d/%h/%b want %0d/%h/%b", tag, i,
                   mem_addr, mem_data_in, mem_rw, da, dd, drw);
        end
        n_checks++;
        if ({busy, cmd_ready, core_stall, done, timeout, trigger, ptr} !==
            {4'b1010, (!completed && i == TO), exp_trigger, exp_ptr}) begin
          n_fail++;
          $display("FAIL %s wait%0d flags: got busy/rdy/stall/done/to=%b trig=%b ptr=%0d want 1010%b trig=%b ptr=%0d",
                   tag, i, {busy, cmd_ready, core_stall, done, timeout}, trigger, ptr,
                   (!completed && i == TO), exp_trigger, exp_ptr);
        end
        tick();
        if (completed) break;
      end
    end
    if (completed) begin
      if (act && len != 0) exp_rp = pout;
      ca = fixed ? PS'(9) : PS'($urandom);
      core_mem_addr = ca; dma_mem_addr = ~ca;
      #1;
      n_checks++;
      if ({cmd_ready, busy, done, timeout, core_stall, trigger, result_page, mem_addr} !==
          {5'b00100, exp_trigger, exp_rp, ca}) begin
        n_fail++;
        $display("FAIL %s done: got rdy/busy/done/to/stall=%b trig=%b rp=%0d addr=%0d want 00100 trig=%b rp=%0d addr=%0d",
                 tag, {cmd_ready, busy, done, timeout, core_stall}, trigger, result_page, mem_addr,
                 exp_trigger, exp_rp, ca);
      end
      tick();
    end
    check_idle({tag, "_post"});
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({trigger, busy, done, timeout, cmd_ready, core_stall, result_page, action, ptr, copy_start, copy_length} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got trig/busy/done/to/rdy/stall=%b rp=%0d latched=%b/%0d/%0d/%0d want all 0",
               {trigger, busy, done, timeout, cmd_ready, core_stall}, result_page, action, ptr, copy_start, copy_length);
    end
    tick(); tick();
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL sync_cycle: got rdy/done=%b want 00", {cmd_ready, done});
    end
    tick();
    check_idle("after_sync");
  endtask

  task automatic test_write_basic();
    run_txn("write_basic", 1'b1, 4'd0, 4'd2, 4'd3, 4, 2'd1, 1'b0, 1'b1);
  endtask

  task automatic test_zero_length();
    run_txn("zero_len", 1'b0, 4'd7, 4'd4, 4'd0, 0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b1, 4'd3, 4'd1, 4'd2, TO, 2'd2, 1'b0, 1'b0);
    ack = ~ack;
    tick();
    check_idle("late_ack_idle");
    tick();
    check_idle("late_ack_idle2");
    run_txn("ack_at_limit", 1'b1, 4'd6, 4'd1, 4'd2, TO - 1, 2'd3, 1'b0, 1'b0);
  endtask

  task automatic test_hold_valid();
    run_txn("hold_valid", 1'b0, 4'd10, 4'd3, 4'd5, 3, 2'd2, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midflight();
    if (ack) begin
      ack = 1'b0;
      tick();
      check_idle("ack_align");
    end
    cmd_valid = 1'b1; cmd_action = 1'b1; cmd_ptr = 4'd12; cmd_start = 4'd1; cmd_length = 4'd5;
    tick();
    cmd_valid = 1'b0;
    tick();
    ack = 1'b1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({trigger, busy, done, timeout, cmd_ready, core_stall, result_page, action, ptr, copy_start, copy_length} !== '0) begin
      n_fail++;
      $display("FAIL midflight_reset: got trig/busy/done/to/rdy/stall=%b rp=%0d latched=%b/%0d/%0d/%0d want all 0",
               {trigger, busy, done, timeout, cmd_ready, core_stall}, result_page, action, ptr, copy_start, copy_length);
    end
    tick(); tick();
    reset_n = 1'b1;
    exp_trigger = 1'b0; exp_rp = '0; exp_act = 1'b0; exp_ptr = '0; exp_start = '0; exp_len = '0;
    #1;
    n_checks++;
    if ({cmd_ready, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL midflight_sync: got rdy/done=%b want 00", {cmd_ready, done});
    end
    tick();
    check_idle("midflight_idle");
    tick();
    check_idle("midflight_idle2");
    run_txn("after_reset", 1'b1, 4'd9, 4'd2, 4'd1, 2, 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic          act;
    logic [PS-1:0] len;
    for (int n = 0; n < 30; n++) begin
      act = 1'($urandom);
      len = ($urandom_range(0, 3) == 0) ? '0 : PS'($urandom_range(1, 15));
      run_txn("random", act, SZ'($urandom), PS'($urandom), len, $urandom_range(0, TO + 2),
              PC'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_zero_length();
    test_timeout();
    test_hold_valid();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
